// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit with valid/ready flow control,
// result flags and a wrapping count of consumed results.
module logic_unit_pipe #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_ones,
    output logic             out_parity,
    output logic [CNT_W-1:0] op_count
);

    typedef struct packed {
        logic [2:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } s1_t;

    s1_t              s1;
    logic             s1_valid;
    logic             s1_en;
    logic             s2_en;
    logic [WIDTH-1:0] res;

    assign s2_en    = !out_valid || out_ready;
    assign s1_en    = !s1_valid || s2_en;
    assign in_ready = s1_en;

    // Operands only load with a real transfer so idle garbage never
    // reaches the datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1       <= '0;
        end else if (s1_en) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1.op <= in_op;
                s1.a  <= in_a;
                s1.b  <= in_b;
            end
        end
    end

    always_comb begin
        res = '0;
        unique case (s1.op)
            3'b000: res = ~(s1.a & s1.b);
            3'b001: res = s1.a & s1.b;
            3'b010: res = s1.a | s1.b;
            3'b011: res = ~(s1.a | s1.b);
            3'b100: res = s1.a ^ s1.b;
            3'b101: res = ~(s1.a ^ s1.b);
            3'b110: res = ~s1.a;
            3'b111: res = s1.b;
        endcase
    end

    // Result and flags update only when a valid op moves in; otherwise
    // they keep their last values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_zero   <= 1'b1;
            out_ones   <= 1'b0;
            out_parity <= 1'b0;
        end else if (s2_en) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_result <= res;
                out_zero   <= (res == '0);
                out_ones   <= &res;
                out_parity <= ^res;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count <= '0;
        end else if (out_valid && out_ready) begin
            op_count <= op_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe: queue scoreboard checked every cycle plus
// directed vectors with literal expectations.
module tb_logic_unit_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_op = '0;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_result;
    logic        out_zero;
    logic        out_ones;
    logic        out_parity;
    logic [1:0]  op_count;

    int nchecks = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    logic_unit_pipe #(.WIDTH(16), .CNT_W(2)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_zero(out_zero),
        .out_ones(out_ones), .out_parity(out_parity),
        .op_count(op_count)
    );

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        nchecks++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] model(input logic [2:0] op,
                                          input logic [15:0] a,
                                          input logic [15:0] b);
        case (op)
            3'd0: return ~(a & b);
            3'd1: return a & b;
            3'd2: return a | b;
            3'd3: return ~(a | b);
            3'd4: return a ^ b;
            3'd5: return ~(a ^ b);
            3'd6: return ~a;
            default: return b;
        endcase
    endfunction

    typedef struct {
        logic [15:0] r;
        int          t;
    } item_t;

    item_t q[$];
    int    cyc = 0;
    int    mcnt = 0;

    // Scoreboard: items in flight, their age in edges, consumed count.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            mcnt = 0;
        end else begin
            chk("in_ready", in_ready, !(q.size() == 2 && !out_ready));
            chk("out_valid", out_valid,
                q.size() > 0 && (cyc - q[0].t) >= 2);
            if (out_valid && q.size() > 0) begin
                chk("result", out_result, q[0].r);
                chk("zero", out_zero, q[0].r == 16'h0000);
                chk("ones", out_ones, q[0].r == 16'hFFFF);
                chk("parity", out_parity, $countones(q[0].r) % 2);
            end
            chk("op_count", op_count, mcnt);
            if (out_valid && out_ready && q.size() > 0) begin
                void'(q.pop_front());
                mcnt = (mcnt + 1) % 4;
            end
            if (in_valid && in_ready) begin
                q.push_back('{r: model(in_op, in_a, in_b), t: cyc});
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_op = 3'($urandom);
        in_a = 16'($urandom);
        in_b = 16'($urandom);
    endtask

    task automatic send(input logic [2:0] op, input logic [15:0] a,
                        input logic [15:0] b);
        logic acc;
        int   n;
        in_valid = 1'b1;
        in_op = op;
        in_a = a;
        in_b = b;
        n = 0;
        do begin
            acc = in_ready;
            tick();
            n++;
        end while (!acc && n < 50);
        if (!acc) chk("send_timeout", 0, 1);
    endtask

    logic [15:0] tbl[8] = '{16'hFF0F, 16'h00F0, 16'h0FF0, 16'hF00F,
                            16'h0F00, 16'hF0FF, 16'hFF0F, 16'h0FF0};
    int seq[$];
    int exp_seq[5] = '{1, 2, 3, 0, 1};

    initial begin
        int c0;
        int prev;
        int acc_n;
        logic acc;

        // reset state
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", out_result, 0);
        chk("rst_zero", out_zero, 1);
        chk("rst_ones", out_ones, 0);
        chk("rst_parity", out_parity, 0);
        chk("rst_op_count", op_count, 0);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk);
        #1 rst = 1'b0;
        tick();

        // single NAND
        send(3'd0, 16'h0000, 16'h0001);
        idle();
        chk("nand_lat0", out_valid, 0);
        tick();
        chk("nand_valid", out_valid, 1);
        chk("nand_res", out_result, 16'hFFFF);
        chk("nand_ones", out_ones, 1);
        chk("nand_zero", out_zero, 0);
        chk("nand_par", out_parity, 0);
        tick();
        tick();

        // back-to-back NAND stream
        c0 = op_count;
        send(3'd0, 16'h000E, 16'h0015);
        send(3'd0, 16'h0003, 16'h00DD);
        idle();
        chk("str_r0", out_result, 16'hFFFB);
        tick();
        chk("str_r1", out_result, 16'hFFFE);
        tick();
        chk("str_cnt", op_count, (c0 + 2) % 4);
        tick();

        // all eight ops
        for (int i = 0; i < 9; i++) begin
            if (i < 8) send(3'(i), 16'h00F0, 16'h0FF0);
            else begin
                idle();
                tick();
            end
            if (i >= 1) chk("allops", out_result, tbl[i-1]);
            if (i == 2) chk("and_zero", out_zero, 0);
            if (i == 5) chk("xor_par", out_parity, 0);
        end
        idle();
        tick();
        tick();

        // backpressure
        c0 = op_count;
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_op = 3'd4;
        in_a = 16'h0011;
        in_b = 16'h0022;
        acc_n = 0;
        for (int i = 0; i < 5; i++) begin
            acc = in_valid && in_ready;
            tick();
            if (acc) begin
                acc_n++;
                in_a = in_a + 16'h0001;
            end
        end
        chk("bp_accepts", acc_n, 2);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_hold", out_result, 16'h0033);
        chk("bp_cnt", op_count, c0);
        idle();
        out_ready = 1'b1;
        tick();
        chk("bp_second", out_result, 16'h0030);
        tick();
        chk("bp_drained", out_valid, 0);

        // counter wrap with a 2-bit counter
        #2 rst = 1'b1;
        @(negedge clk);
        #1 rst = 1'b0;
        tick();
        prev = op_count;
        for (int k = 0; k < 12; k++) begin
            if (k < 5) begin
                in_valid = 1'b1;
                in_op = 3'(k);
                in_a = 16'(k * 16'h1111);
                in_b = 16'h5A5A;
            end else idle();
            tick();
            if (op_count != prev) seq.push_back(int'(op_count));
            prev = op_count;
        end
        chk("wrap_len", seq.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < seq.size()) chk("wrap_seq", seq[i], exp_seq[i]);
        end

        // reset with two ops in flight
        send(3'd2, 16'h1234, 16'h0001);
        send(3'd3, 16'h1234, 16'h0001);
        idle();
        chk("pre_rst_valid", out_valid, 1);
        #1 rst = 1'b1;
        #1;
        chk("async_valid", out_valid, 0);
        chk("async_cnt", op_count, 0);
        @(negedge clk);
        #1 rst = 1'b0;
        tick();
        send(3'd1, 16'hFFFF, 16'h0F0F);
        idle();
        chk("post_lat0", out_valid, 0);
        tick();
        chk("post_valid", out_valid, 1);
        chk("post_res", out_result, 16'h0F0F);
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
